// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the generic pipeline stage register.
// The skid buffer is enabled by defining PIPE_STAGE_SKID_EN.
package pipe_stage_pkg;

   localparam int PIPE_CTRL_W = 10;
   localparam int PIPE_DATA_W = 133;

   // Bit positions inside the control field, MSB first.
   localparam int CTRL_WREG_BIT   = 9;
   localparam int CTRL_M2REG_BIT  = 8;
   localparam int CTRL_WMEM_BIT   = 7;
   localparam int CTRL_ALUIMM_BIT = 6;
   localparam int CTRL_SHIFT_BIT  = 5;
   localparam int CTRL_JAL_BIT    = 4;
   localparam int CTRL_ALUC_MSB   = 3;
   localparam int CTRL_ALUC_LSB   = 0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One storage slot of the pipeline stage: valid + ctrl + data.
// Kill has priority over load and clears valid and ctrl while holding data.
module pipe_stage_slot
   import pipe_stage_pkg::*;
#(
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int DATA_W = PIPE_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              kill,
   input  logic [CTRL_W-1:0] load_ctrl,
   input  logic [DATA_W-1:0] load_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   logic              valid_r;
   logic [CTRL_W-1:0] ctrl_r;
   logic [DATA_W-1:0] data_r;

   // Slot register: kill zeroes valid/ctrl, load captures a new beat.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_r <= 1'b0;
         ctrl_r  <= {CTRL_W{1'b0}};
         data_r  <= {DATA_W{1'b0}};
      end else if (kill) begin
         valid_r <= 1'b0;
         ctrl_r  <= {CTRL_W{1'b0}};
      end else if (load) begin
         valid_r <= 1'b1;
         ctrl_r  <= load_ctrl;
         data_r  <= load_data;
      end
   end

   assign valid = valid_r;
   assign ctrl  = ctrl_r;
   assign data  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake and flush.
// Define PIPE_STAGE_SKID_EN to add a skid slot so in_ready is registered.
module pipe_stage_reg
   import pipe_stage_pkg::*;
#(
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int DATA_W = PIPE_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
);

   stage_state_t      state_r;
   stage_state_t      state_nxt_s;
   logic              in_fire_s;
   logic              out_fire_s;
   logic              main_load_s;
   logic              main_kill_s;
   logic [CTRL_W-1:0] main_ctrl_in_s;
   logic [DATA_W-1:0] main_data_in_s;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_load_s;
   logic              skid_kill_s;
   logic              skid_valid_s;
   logic [CTRL_W-1:0] skid_ctrl_s;
   logic [DATA_W-1:0] skid_data_s;

   assign in_ready       = (state_r != ST_TWO) && !flush;
   // An occupied skid slot always refills the main slot before new input does.
   assign main_ctrl_in_s = skid_valid_s ? skid_ctrl_s : in_ctrl;
   assign main_data_in_s = skid_valid_s ? skid_data_s : in_data;

   pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clock     (clock),
      .reset     (reset),
      .load      (skid_load_s),
      .kill      (skid_kill_s),
      .load_ctrl (in_ctrl),
      .load_data (in_data),
      .valid     (skid_valid_s),
      .ctrl      (skid_ctrl_s),
      .data      (skid_data_s)
   );
`else
   assign in_ready       = (!out_valid || out_ready) && !flush;
   assign main_ctrl_in_s = in_ctrl;
   assign main_data_in_s = in_data;
`endif

   assign in_fire_s  = in_valid && in_ready;
   assign out_fire_s = out_valid && out_ready;

   // Occupancy state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and slot control decode.
   always_comb begin
      state_nxt_s = state_r;
      main_load_s = 1'b0;
      main_kill_s = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_load_s = 1'b0;
      skid_kill_s = 1'b0;
`endif
      if (flush) begin
         state_nxt_s = ST_EMPTY;
         main_kill_s = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
         skid_kill_s = 1'b1;
`endif
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  state_nxt_s = ST_ONE;
                  main_load_s = 1'b1;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (in_fire_s && out_fire_s) begin
                  main_load_s = 1'b1;
               end else if (in_fire_s) begin
`ifdef PIPE_STAGE_SKID_EN
                  state_nxt_s = ST_TWO;
                  skid_load_s = 1'b1;
`else
                  state_nxt_s = ST_ONE;
`endif
               end else if (out_fire_s) begin
                  state_nxt_s = ST_EMPTY;
                  main_kill_s = 1'b1;
               end else begin
                  state_nxt_s = ST_ONE;
               end
            end
            ST_TWO: begin
`ifdef PIPE_STAGE_SKID_EN
               if (out_fire_s) begin
                  state_nxt_s = ST_ONE;
                  main_load_s = 1'b1;
                  skid_kill_s = 1'b1;
               end else begin
                  state_nxt_s = ST_TWO;
               end
`else
               state_nxt_s = ST_EMPTY;
               main_kill_s = 1'b1;
`endif
            end
            default: begin
               state_nxt_s = ST_EMPTY;
               main_kill_s = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
               skid_kill_s = 1'b1;
`endif
            end
         endcase
      end
   end

   pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clock     (clock),
      .reset     (reset),
      .load      (main_load_s),
      .kill      (main_kill_s),
      .load_ctrl (main_ctrl_in_s),
      .load_data (main_data_in_s),
      .valid     (out_valid),
      .ctrl      (out_ctrl),
      .data      (out_data)
   );

endmodule
